// File: rtl/video_pkg.sv
// Shared types and widths for the HDMI line-buffer path.
// Holds pixel width, level width and FSM state encodings.
package video_pkg;

    localparam int PIX_W     = 24;
    localparam int DEPTH_DEF = 200;
    localparam int LEVEL_W   = $clog2(DEPTH_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_FILL   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_level_cnt.sv
// Up/down occupancy counter for the line FIFO.
// Saturates at 0 and DEPTH; clr forces zero.
module fifo_level_cnt
    import video_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = LEVEL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] level,
    output logic [W-1:0] level_nxt,
    output logic         empty,
    output logic         full
);

    assign empty = (level == '0);
    assign full  = (level == W'(DEPTH));

    always_comb begin
        level_nxt = level;
        if (clr)
            level_nxt = '0;
        else if (inc && !dec && !full)
            level_nxt = level + W'(1);
        else if (dec && !inc && !empty)
            level_nxt = level - W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            level <= '0;
        else
            level <= level_nxt;
    end

endmodule

// File: rtl/line_fifo_ctrl.sv
// Sequencer for the RGB line FIFO: flush, preload, stream.
// Drives the fifo enables and reports occupancy and sticky errors.
module line_fifo_ctrl
    import video_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PRELOAD  = 16,
    parameter int FLUSH_CY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vs,
    input  logic               in_de,
    input  logic [PIX_W-1:0]   in_data,
    input  logic               out_req,
    output logic               fifo_rst_n,
    output logic               fifo_wr_en,
    output logic [PIX_W-1:0]   fifo_wr_data,
    output logic               fifo_rd_en,
    output logic               out_valid,
    output logic [LEVEL_W-1:0] level,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    output logic               underflow,
    output logic [1:0]         state
);

    localparam int FC_W = (FLUSH_CY > 1) ? $clog2(FLUSH_CY) : 1;

    state_t             cur_st;
    state_t             nxt_st;
    logic [FC_W-1:0]    flush_cnt;
    logic [FC_W-1:0]    flush_nxt;
    logic [LEVEL_W-1:0] level_nxt;
    logic               in_flush;
    logic               clr;
    logic               drop;
    logic               uflow;

    assign in_flush     = (cur_st == ST_FLUSH);
    assign clr          = in_vs | in_flush;
    assign fifo_rst_n   = !in_flush;
    assign fifo_wr_data = in_data;
    assign state        = cur_st;

    assign fifo_rd_en = (cur_st == ST_STREAM) & out_req & !empty;
    assign fifo_wr_en = in_de & !in_vs & !in_flush & (!full | fifo_rd_en);

    // pixels lost during vs/flush are realignment, not overflow
    assign drop  = in_de & !fifo_wr_en & !in_vs & !in_flush;
    assign uflow = (cur_st == ST_STREAM) & out_req & empty;

    fifo_level_cnt #(
        .DEPTH (DEPTH),
        .W     (LEVEL_W)
    ) u_level (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .inc       (fifo_wr_en),
        .dec       (fifo_rd_en),
        .level     (level),
        .level_nxt (level_nxt),
        .empty     (empty),
        .full      (full)
    );

    always_comb begin
        nxt_st    = cur_st;
        flush_nxt = flush_cnt;
        if (in_vs) begin
            nxt_st    = ST_FLUSH;
            flush_nxt = '0;
        end else begin
            unique case (cur_st)
                ST_IDLE: begin
                    if (fifo_wr_en)
                        nxt_st = ST_FILL;
                end
                ST_FLUSH: begin
                    if (flush_cnt == FC_W'(FLUSH_CY - 1))
                        nxt_st = ST_IDLE;
                    else
                        flush_nxt = flush_cnt + FC_W'(1);
                end
                ST_FILL: begin
                    // short lines stream whatever they buffered
                    if (level_nxt >= LEVEL_W'(PRELOAD))
                        nxt_st = ST_STREAM;
                    else if (!in_de && level != '0)
                        nxt_st = ST_STREAM;
                end
                ST_STREAM: begin
                    if (!in_de && level == '0 && !fifo_wr_en)
                        nxt_st = ST_IDLE;
                end
                default: nxt_st = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st    <= ST_IDLE;
            flush_cnt <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            cur_st    <= nxt_st;
            flush_cnt <= flush_nxt;
            out_valid <= fifo_rd_en;
            if (clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                overflow  <= overflow | drop;
                underflow <= underflow | uflow;
            end
        end
    end

endmodule

// File: tb/tb_line_fifo_ctrl.sv
// Directed bench for line_fifo_ctrl with a behavioural fifo
// and a pixel scoreboard checked on out_valid.
module tb_line_fifo_ctrl;
    import video_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_vs;
    logic               in_de;
    logic [PIX_W-1:0]   in_data;
    logic               out_req;
    logic               fifo_rst_n;
    logic               fifo_wr_en;
    logic [PIX_W-1:0]   fifo_wr_data;
    logic               fifo_rd_en;
    logic               out_valid;
    logic [LEVEL_W-1:0] level;
    logic               empty;
    logic               full;
    logic               overflow;
    logic               underflow;
    logic [1:0]         state;

    int checks   = 0;
    int failures = 0;
    int pix      = 0;

    logic [PIX_W-1:0] exp_q[$];
    logic [PIX_W-1:0] mem[$];
    logic [PIX_W-1:0] rd_data;

    logic       last_wr;
    logic       last_rd;
    logic       last_rst;
    logic [1:0] last_state;
    logic [7:0] last_level;

    always #5 clk = ~clk;

    line_fifo_ctrl #(
        .DEPTH    (200),
        .PRELOAD  (16),
        .FLUSH_CY (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vs        (in_vs),
        .in_de        (in_de),
        .in_data      (in_data),
        .out_req      (out_req),
        .fifo_rst_n   (fifo_rst_n),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_rd_en   (fifo_rd_en),
        .out_valid    (out_valid),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .underflow    (underflow),
        .state        (state)
    );

    // behavioural 1-cycle-latency fifo standing in for the real instance
    always @(posedge clk) begin
        logic [PIX_W-1:0] t;
        if (!fifo_rst_n) begin
            mem.delete();
        end else begin
            if (fifo_rd_en && mem.size() > 0) begin
                t = mem.pop_front();
                rd_data <= t;
            end
            if (fifo_wr_en)
                mem.push_back(fifo_wr_data);
        end
    end

    always @(negedge clk) begin
        logic [PIX_W-1:0] e;
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL out_data observed=%h expected=none", rd_data);
                end
            end else begin
                e = exp_q.pop_front();
                assert (rd_data === e) else begin
                    failures++;
                    $error("FAIL out_data observed=%h expected=%h", rd_data, e);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic vs, input logic de, input logic req,
                       input bit acc);
        in_vs   = vs;
        in_de   = de;
        out_req = req;
        in_data = 24'hA50000 ^ 24'(pix);
        if (de && acc)
            exp_q.push_back(in_data);
        if (de)
            pix++;
        @(negedge clk);
        last_wr    = fifo_wr_en;
        last_rd    = fifo_rd_en;
        last_rst   = fifo_rst_n;
        last_state = state;
        last_level = level;
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        int first_lvl;
        int rd_cnt;
        int full_at;
        int ovf_at;
        int max_lvl;
        int both;

        rst_n   = 1'b0;
        in_vs   = 1'b0;
        in_de   = 1'b0;
        in_data = '0;
        out_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_level", 32'(level), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_underflow", 32'(underflow), 0);
        check("rst_fifo_rst_n", 32'(fifo_rst_n), 1);
        rst_n = 1'b1;

        // 1: frame-start flush
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("vs_to_flush", 32'(state), 32'(ST_FLUSH));
        low_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (!last_rst) low_cnt++;
        end
        check("flush_low_cycles", 32'(low_cnt), 2);
        check("flush_end_state", 32'(state), 32'(ST_IDLE));
        check("flush_end_level", 32'(level), 0);

        // 2: preload then stream with continuous request
        first_lvl = -1;
        rd_cnt    = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1);
            if (last_rd) begin
                rd_cnt++;
                if (first_lvl < 0) first_lvl = int'(last_level);
            end
        end
        check("first_rd_level", 32'(first_lvl), 16);
        check("rd_during_line", 32'(rd_cnt), 4);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            if (last_rd) rd_cnt++;
            if (state == ST_IDLE) break;
        end
        check("rd_total", 32'(rd_cnt), 20);
        check("drain_state", 32'(state), 32'(ST_IDLE));
        check("drain_level", 32'(level), 0);
        check("drain_underflow", 32'(underflow), 1);
        check("drain_sb_empty", 32'(exp_q.size()), 0);

        // 3: saturate at DEPTH with no reads
        flush();
        check("flush_clr_underflow", 32'(underflow), 0);
        full_at = -1;
        ovf_at  = -1;
        max_lvl = 0;
        for (int i = 0; i < 210; i++) begin
            cyc(1'b0, 1'b1, 1'b0, i < 200);
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (full && full_at < 0) full_at = i;
            if (overflow && ovf_at < 0) ovf_at = i;
        end
        check("sat_max_level", 32'(max_lvl), 200);
        check("sat_full_cycle", 32'(full_at), 199);
        check("sat_ovf_cycle", 32'(ovf_at), 200);
        check("sat_full_flag", 32'(full), 1);
        check("sat_drop_no_wr", 32'(last_wr), 0);
        check("sat_state", 32'(state), 32'(ST_STREAM));

        // 4: write while full only with a same-cycle read
        flush();
        check("flush_clr_overflow", 32'(overflow), 0);
        for (int i = 0; i < 200; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("full_again", 32'(full), 1);
        both = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1);
            if (last_wr && last_rd) both++;
        end
        check("full_wr_rd", 32'(both), 5);
        check("full_level_hold", 32'(level), 200);
        check("full_no_overflow", 32'(overflow), 0);

        // 5: short 8-pixel line
        flush();
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("short_fill_level", 32'(last_level), 8);
        check("short_fill_state", 32'(last_state), 32'(ST_FILL));
        check("short_to_stream", 32'(state), 32'(ST_STREAM));
        rd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            if (last_rd) rd_cnt++;
            if (state == ST_IDLE) break;
        end
        check("short_reads", 32'(rd_cnt), 8);
        check("short_idle", 32'(state), 32'(ST_IDLE));
        check("short_level", 32'(level), 0);
        check("short_underflow", 32'(underflow), 1);

        // 6: frame start in the middle of streaming
        for (int i = 0; i < 50; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("mid_level", 32'(level), 50);
        check("mid_state", 32'(state), 32'(ST_STREAM));
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("vs_pixel_not_written", 32'(last_wr), 0);
        check("mid_flush_state", 32'(state), 32'(ST_FLUSH));
        check("mid_flush_level", 32'(level), 0);
        check("mid_flush_underflow", 32'(underflow), 0);
        check("mid_flush_overflow", 32'(overflow), 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        check("mid_end_state", 32'(state), 32'(ST_IDLE));
        check("mid_end_level", 32'(level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
